// File: rtl/cpu_if.sv
// Debug/retire observation bundle of the cpu core.
// Latency: pure wiring, no storage.
// Backpressure: none; the core drives these every cycle and nobody can stall it.
interface cpu_if;
    logic [31:0] dbg_pc;
    logic        dbg_wb_en;
    logic [4:0]  dbg_wb_rd;
    logic [31:0] dbg_wb_data;

    modport master (output dbg_pc, dbg_wb_en, dbg_wb_rd, dbg_wb_data);
    modport slave  (input  dbg_pc, dbg_wb_en, dbg_wb_rd, dbg_wb_data);
endinterface

// File: rtl/cpu.sv
// Single-cycle RV32I subset core with internal instruction/data RAMs; optional M multiply via CPU_MUL_EN.
// Latency: one instruction fetched, executed and retired per rising clk edge.
// Backpressure: none; the core never stalls, clr (async, active-low) restarts it at RESET_PC.

// Word-addressed RAM: combinational read, write on clk edge, byte address bits [1:0] ignored.
module cpu_ram #(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    reg   [31:0]   ramdata [0:WORDS-1];
    logic [29:0]   word_idx;
    logic [AW-1:0] idx;

    // Index wraps modulo the depth so any 32-bit address lands inside the array.
    assign word_idx = addr[31:2] % 30'(WORDS);
    assign idx      = word_idx[AW-1:0];
    assign rdata    = ramdata[idx];

    wire unused_ok = ^{addr[1:0], word_idx};

    // Memory contents are never reset; writes happen only when we is high.
    always_ff @(posedge clk) begin
        if (we) ramdata[idx] <= wdata;
    end
endmodule

module cpu #(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic   clk,
    input  logic   clr,
    cpu_if.master  dbg
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] instr;
    logic [31:0] rf_q [0:31];

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_v, rs2_v;
    logic [4:0]  shamt_r;

    logic        wb_en, wb_we, take;
    logic [31:0] wb_data;
    logic        dm_we;
    logic [31:0] dm_addr, dm_rdata;

    cpu_ram #(.WORDS(IMEM_WORDS)) RAM_Instruction (
        .clk   (clk),
        .we    (1'b0),
        .addr  (pc_q),
        .wdata (32'h0),
        .rdata (instr)
    );

    cpu_ram #(.WORDS(DMEM_WORDS)) RAM_Data (
        .clk   (clk),
        .we    (dm_we & clr),
        .addr  (dm_addr),
        .wdata (rs2_v),
        .rdata (dm_rdata)
    );

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1_v   = (rs1 == 5'd0) ? 32'h0 : rf_q[rs1];
    assign rs2_v   = (rs2 == 5'd0) ? 32'h0 : rf_q[rs2];
    assign shamt_r = rs2_v[4:0];

    // Kept outside the decode block so the RAM read does not loop back through it.
    assign dm_addr = rs1_v + ((opcode == OPC_STORE) ? imm_s : imm_i);

`ifdef CPU_MUL_EN
    logic [63:0] prod_ss, prod_su, prod_uu;
    // Sign-extend to 64 bits so a plain modular multiply yields the signed product.
    assign prod_ss = {{32{rs1_v[31]}}, rs1_v} * {{32{rs2_v[31]}}, rs2_v};
    assign prod_su = {{32{rs1_v[31]}}, rs1_v} * {32'h0, rs2_v};
    assign prod_uu = {32'h0, rs1_v} * {32'h0, rs2_v};
`endif

    // Decode/execute: next PC, writeback value and store enable for this instruction.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        pc_d     = pc_plus4;
        wb_en    = 1'b0;
        wb_data  = 32'h0;
        dm_we    = 1'b0;
        take     = 1'b0;
        case (opcode)
            OPC_LUI: begin
                wb_en   = 1'b1;
                wb_data = imm_u;
            end
            OPC_AUIPC: begin
                wb_en   = 1'b1;
                wb_data = pc_q + imm_u;
            end
            OPC_JAL: begin
                wb_en   = 1'b1;
                wb_data = pc_plus4;
                pc_d    = pc_q + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    wb_en   = 1'b1;
                    wb_data = pc_plus4;
                    pc_d    = (rs1_v + imm_i) & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  take = (rs1_v == rs2_v);
                    3'b001:  take = (rs1_v != rs2_v);
                    3'b100:  take = ($signed(rs1_v) <  $signed(rs2_v));
                    3'b101:  take = ($signed(rs1_v) >= $signed(rs2_v));
                    3'b110:  take = (rs1_v <  rs2_v);
                    3'b111:  take = (rs1_v >= rs2_v);
                    default: take = 1'b0;
                endcase
                if (take) pc_d = pc_q + imm_b;
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010) begin
                    wb_en   = 1'b1;
                    wb_data = dm_rdata;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) dm_we = 1'b1;
            end
            OPC_OPIMM: begin
                wb_en = 1'b1;
                case (funct3)
                    3'b000: wb_data = rs1_v + imm_i;
                    3'b010: wb_data = {31'h0, $signed(rs1_v) < $signed(imm_i)};
                    3'b011: wb_data = {31'h0, rs1_v < imm_i};
                    3'b100: wb_data = rs1_v ^ imm_i;
                    3'b110: wb_data = rs1_v | imm_i;
                    3'b111: wb_data = rs1_v & imm_i;
                    3'b001: begin
                        if (funct7 == 7'b0000000) wb_data = rs1_v << rs2;
                        else                      wb_en   = 1'b0;
                    end
                    default: begin
                        if (funct7 == 7'b0000000)      wb_data = rs1_v >> rs2;
                        else if (funct7 == 7'b0100000) wb_data = $unsigned($signed(rs1_v) >>> rs2);
                        else                           wb_en   = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    wb_en = 1'b1;
                    case (funct3)
                        3'b000:  wb_data = rs1_v + rs2_v;
                        3'b001:  wb_data = rs1_v << shamt_r;
                        3'b010:  wb_data = {31'h0, $signed(rs1_v) < $signed(rs2_v)};
                        3'b011:  wb_data = {31'h0, rs1_v < rs2_v};
                        3'b100:  wb_data = rs1_v ^ rs2_v;
                        3'b101:  wb_data = rs1_v >> shamt_r;
                        3'b110:  wb_data = rs1_v | rs2_v;
                        default: wb_data = rs1_v & rs2_v;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin
                        wb_en   = 1'b1;
                        wb_data = rs1_v - rs2_v;
                    end else if (funct3 == 3'b101) begin
                        wb_en   = 1'b1;
                        wb_data = $unsigned($signed(rs1_v) >>> shamt_r);
                    end
                end
`ifdef CPU_MUL_EN
                else if (funct7 == 7'b0000001) begin
                    // Divide/remainder encodings (funct3[2]=1) stay NOPs.
                    wb_en = ~funct3[2];
                    case (funct3[1:0])
                        2'b00:   wb_data = prod_uu[31:0];
                        2'b01:   wb_data = prod_ss[63:32];
                        2'b10:   wb_data = prod_su[63:32];
                        default: wb_data = prod_uu[63:32];
                    endcase
                end
`endif
            end
            default: ;
        endcase
    end

    // Writes to x0 are dropped and nothing commits while clr holds the core in reset.
    assign wb_we = wb_en & (rd != 5'd0) & clr;

    // Program counter commit.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) pc_q <= RESET_PC;
        else      pc_q <= pc_d;
    end

    // Register file: cleared by reset, one write per edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
        end else if (wb_we) begin
            rf_q[rd] <= wb_data;
        end
    end

    assign dbg.dbg_pc      = pc_q;
    assign dbg.dbg_wb_en   = wb_we;
    assign dbg.dbg_wb_rd   = rd;
    assign dbg.dbg_wb_data = wb_data;
endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: loads a program image, then checks the per-cycle retire trace.
// Latency: one table record per clock edge.
// Backpressure: none.
module tb_cpu;
    logic clk;
    logic clr;
    cpu_if dbg_if ();

    cpu #(.IMEM_WORDS(256), .DMEM_WORDS(256), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .clr (clr),
        .dbg (dbg_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPR = 7'b0110011;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] instr, input logic [31:0] pc, input logic en,
                       input int rd, input logic [31:0] data);
        vec_t v;
        v.instr = instr; v.pc = pc; v.en = en; v.rd = 5'(rd); v.data = data;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OPR};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm20;
        return {v[19:0], 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction

    initial begin
        logic [31:0] trap;
        clr = 1'b0;

        // Expected retire trace; loops repeat the same PC/instruction.
        add(enc_i(5, 0, 0, 1, OPI),            32'h00, 1, 1,  32'h5);
        add(enc_i(-3, 0, 0, 2, OPI),           32'h04, 1, 2,  32'hFFFFFFFD);
        add(enc_r(0, 2, 1, 0, 3),              32'h08, 1, 3,  32'h2);
        add(enc_r(32, 1, 2, 0, 4),             32'h0C, 1, 4,  32'hFFFFFFF8);
        add(enc_s(8, 1, 0),                    32'h10, 0, 0,  32'h0);
        add(enc_i(8, 0, 2, 5, 7'b0000011),     32'h14, 1, 5,  32'h5);
        add(enc_i(7, 0, 0, 0, OPI),            32'h18, 0, 0,  32'h0);
        add(enc_i(3, 0, 0, 7, OPI),            32'h1C, 1, 7,  32'h3);
        add(enc_j(8, 1),                       32'h20, 1, 1,  32'h24);
        add(enc_u(32'h12345, 8, 7'b0110111),   32'h28, 1, 8,  32'h12345000);
        add(enc_i(0, 0, 0, 6, OPI),            32'h2C, 1, 6,  32'h0);
        add(enc_i(1, 6, 0, 6, OPI),            32'h30, 1, 6,  32'h1);
        add(enc_b(-4, 7, 6, 1),                32'h34, 0, 0,  32'h0);
        add(enc_i(1, 6, 0, 6, OPI),            32'h30, 1, 6,  32'h2);
        add(enc_b(-4, 7, 6, 1),                32'h34, 0, 0,  32'h0);
        add(enc_i(1, 6, 0, 6, OPI),            32'h30, 1, 6,  32'h3);
        add(enc_b(-4, 7, 6, 1),                32'h34, 0, 0,  32'h0);
        add(enc_u(1, 10, 7'b0010111),          32'h38, 1, 10, 32'h1038);
        add(enc_i(0, 2, 2, 11, OPI),           32'h3C, 1, 11, 32'h1);
        add(enc_i(5, 2, 3, 12, OPI),           32'h40, 1, 12, 32'h0);
        add(enc_i(32'h401, 4, 5, 13, OPI),     32'h44, 1, 13, 32'hFFFFFFFC);
        add(enc_i(28, 4, 5, 14, OPI),          32'h48, 1, 14, 32'hF);
        add(enc_i(4, 1, 1, 15, OPI),           32'h4C, 1, 15, 32'h240);
        add(enc_i(-1, 1, 4, 16, OPI),          32'h50, 1, 16, 32'hFFFFFFDB);
        add(enc_r(0, 1, 2, 2, 17),             32'h54, 1, 17, 32'h1);
        add(enc_r(0, 1, 2, 3, 18),             32'h58, 1, 18, 32'h0);
        add(enc_b(8, 1, 2, 4),                 32'h5C, 0, 0,  32'h0);
        add(enc_b(8, 2, 1, 7),                 32'h64, 0, 0,  32'h0);
        add(enc_i(32'h51, 1, 0, 19, 7'b1100111), 32'h68, 1, 19, 32'h6C);
        add(enc_r(0, 1, 1, 0, 1),              32'h74, 1, 1,  32'h48);
        add(32'h00000073,                      32'h78, 0, 0,  32'h0);
        add(enc_i(7, 0, 0, 21, OPI),           32'h7C, 1, 21, 32'h7);
        add(enc_i(-6, 0, 0, 22, OPI),          32'h80, 1, 22, 32'hFFFFFFFA);
`ifdef CPU_MUL_EN
        add(enc_r(1, 22, 21, 0, 20),           32'h84, 1, 20, 32'hFFFFFFD6);
`else
        add(enc_r(1, 22, 21, 0, 20),           32'h84, 0, 0,  32'h0);
`endif
        add(enc_i(-1, 0, 0, 23, OPI),          32'h88, 1, 23, 32'hFFFFFFFF);
        add(enc_i(2, 0, 0, 24, OPI),           32'h8C, 1, 24, 32'h2);
`ifdef CPU_MUL_EN
        add(enc_r(1, 24, 23, 3, 25),           32'h90, 1, 25, 32'h1);
`else
        add(enc_r(1, 24, 23, 3, 25),           32'h90, 0, 0,  32'h0);
`endif
        add(enc_r(0, 22, 21, 7, 26),           32'h94, 1, 26, 32'h2);
        add(enc_r(0, 22, 21, 6, 27),           32'h98, 1, 27, 32'hFFFFFFFF);
        add(enc_i(11, 0, 2, 28, 7'b0000011),   32'h9C, 1, 28, 32'h5);
        add(enc_j(32'h360, 0),                 32'hA0, 0, 0,  32'h0);
        add(enc_i(5, 0, 0, 1, OPI),            32'h400, 1, 1, 32'h5);
        add(enc_i(-3, 0, 0, 2, OPI),           32'h404, 1, 2, 32'hFFFFFFFD);

        // Unused words hold a write to x31 so a stray fetch shows up in the trace.
        trap = enc_i(-1, 0, 0, 31, OPI);
        for (int i = 0; i < 256; i++) dut.RAM_Instruction.ramdata[i] = trap;
        foreach (tbl[i]) dut.RAM_Instruction.ramdata[(tbl[i].pc >> 2) % 256] = tbl[i].instr;

        // Reset state while clr is held low.
        #10;
        chk("reset_pc", dbg_if.dbg_pc, 32'h0);
        chk("reset_wb_en", {31'h0, dbg_if.dbg_wb_en}, 32'h0);
        for (int r = 1; r < 32; r++) chk($sformatf("reset_x%0d", r), dut.rf_q[r], 32'h0);
        #10;
        clr = 1'b1;
        #1;

        foreach (tbl[i]) begin
            chk($sformatf("v%0d_pc", i), dbg_if.dbg_pc, tbl[i].pc);
            chk($sformatf("v%0d_wb_en", i), {31'h0, dbg_if.dbg_wb_en}, {31'h0, tbl[i].en});
            if (tbl[i].en) begin
                chk($sformatf("v%0d_wb_rd", i), {27'h0, dbg_if.dbg_wb_rd}, {27'h0, tbl[i].rd});
                chk($sformatf("v%0d_wb_data", i), dbg_if.dbg_wb_data, tbl[i].data);
            end
            @(posedge clk);
            #1;
        end

        // Architectural state after the trace.
        chk("x0_zero", dut.rf_q[0], 32'h0);
        chk("x3_add", dut.rf_q[3], 32'h2);
        chk("x6_loop", dut.rf_q[6], 32'h3);
        chk("x8_lui", dut.rf_q[8], 32'h12345000);
        chk("x31_no_stray", dut.rf_q[31], 32'h0);
`ifdef CPU_MUL_EN
        chk("x20_mul", dut.rf_q[20], 32'hFFFFFFD6);
`else
        chk("x20_untouched", dut.rf_q[20], 32'h0);
`endif

        // Mid-program reset: asynchronous clear, hold across an edge, restart at 0.
        #2;
        clr = 1'b0;
        #1;
        chk("midrst_pc", dbg_if.dbg_pc, 32'h0);
        chk("midrst_wb_en", {31'h0, dbg_if.dbg_wb_en}, 32'h0);
        chk("midrst_x3", dut.rf_q[3], 32'h0);
        @(posedge clk);
        #1;
        chk("midrst_hold_pc", dbg_if.dbg_pc, 32'h0);
        chk("midrst_hold_x1", dut.rf_q[1], 32'h0);
        #2;
        clr = 1'b1;
        #1;
        chk("restart_pc", dbg_if.dbg_pc, 32'h0);
        chk("restart_wb_en", {31'h0, dbg_if.dbg_wb_en}, 32'h1);
        @(posedge clk);
        #1;
        chk("restart_pc2", dbg_if.dbg_pc, 32'h4);
        chk("restart_x1", dut.rf_q[1], 32'h5);
        chk("restart_x2", dut.rf_q[2], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
